// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for the instruction ROM: owns the PC, issues ROM reads and
// holds one fetched word for decode behind a valid/ready handshake.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned ROM_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        rom_en,
  output logic [31:0] rom_pc,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_nxt, opc_nxt;
  logic        valid_nxt, fault_nxt;
  logic        pc_legal, redirect_legal, capture;

  // Bounds check is done in 33 bits so a PC near 2^32 cannot wrap into range.
  function automatic logic legal(input logic [31:0] a);
    logic [32:0] last_byte;
    last_byte = {1'b0, a} + 33'd3;
    return (a[1:0] == 2'b00) && (last_byte <= (33'(ROM_BYTES) - 33'd1));
  endfunction

  assign rom_pc         = pc;
  assign pc_legal       = legal(pc);
  assign redirect_legal = legal(redirect_pc);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = out_valid;
    instr_nxt = out_instr;
    opc_nxt   = out_pc;
    fault_nxt = fault;
    rom_en    = 1'b0;
    capture   = 1'b0;

    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        rom_en = pc_legal;
        if (!pc_legal) begin
          state_nxt = HALT;
          fault_nxt = 1'b1;
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase

    if (out_valid && out_ready)
      valid_nxt = 1'b0;

    capture = (state == FETCH) && pc_legal && !redirect_valid &&
              (!out_valid || out_ready);
    if (capture) begin
      valid_nxt = 1'b1;
      instr_nxt = rom_data;
      opc_nxt   = pc;
      pc_nxt    = pc + 32'd4;
    end

    // A redirect flushes the held word; a same-cycle handshake on it still completes.
    if (redirect_valid) begin
      valid_nxt = 1'b0;
      pc_nxt    = redirect_pc;
      state_nxt = redirect_legal ? FETCH : HALT;
      fault_nxt = !redirect_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_pc    <= 32'h0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      out_valid <= valid_nxt;
      out_instr <= instr_nxt;
      out_pc    <= opc_nxt;
      fault     <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios followed by random traffic,
// all compared every cycle against a transaction-level reference model.
module tb_instr_fetch_ctrl;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam int unsigned ROM_BYTES = 32;

  logic        clk;
  logic        reset;
  logic        rom_en;
  logic [31:0] rom_pc;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  logic [31:0] rom_mem [8];

  int checks = 0;
  int errors = 0;

  // Reference model: fetch pointer, one-word output slot, and run mode.
  logic [31:0] m_pc;
  bit          m_idle, m_halt, m_fault, m_valid;
  logic [31:0] m_instr, m_opc;

  instr_fetch_ctrl #(.RESET_PC(RESET_PC), .ROM_BYTES(ROM_BYTES)) dut (
    .clk(clk), .reset(reset), .rom_en(rom_en), .rom_pc(rom_pc),
    .rom_data(rom_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rom_data = (rom_pc < ROM_BYTES) ? rom_mem[rom_pc[4:2]] : 32'hDEAD_BEEF;

  function automatic bit mlegal(input logic [31:0] a);
    longint unsigned last_byte;
    last_byte = longint'(a) + 3;
    return (a % 4 == 0) && (last_byte <= ROM_BYTES - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    check("out_pc",    out_pc,    m_opc);
    check("out_instr", out_instr, m_instr);
    check("fault",     {31'b0, fault}, {31'b0, m_fault});
    check("rom_pc",    rom_pc,    m_pc);
    check("rom_en",    {31'b0, rom_en},
          {31'b0, (!m_idle && !m_halt && mlegal(m_pc))});
  endtask

  // Advance the model by one edge using the inputs currently applied, then
  // let the DUT take the same edge and compare.
  task automatic tick();
    if (reset) begin
      m_pc = RESET_PC; m_idle = 1; m_halt = 0; m_fault = 0;
      m_valid = 0; m_instr = 0; m_opc = 0;
    end else begin
      if (m_valid && out_ready) m_valid = 0;
      if (redirect_valid) begin
        m_valid = 0;
        m_pc    = redirect_pc;
        m_idle  = 0;
        m_halt  = !mlegal(redirect_pc);
        m_fault = !mlegal(redirect_pc);
      end else if (m_idle) begin
        m_idle = 0;
      end else if (!m_halt) begin
        if (!mlegal(m_pc)) begin
          m_halt  = 1;
          m_fault = 1;
        end else if (!m_valid) begin
          m_instr = rom_mem[m_pc / 4];
          m_opc   = m_pc;
          m_valid = 1;
          m_pc    = m_pc + 4;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1; redirect_valid = 0; redirect_pc = 0;
    tick();
    reset = 0;
  endtask

  initial begin
    reset = 1; out_ready = 1; redirect_valid = 0; redirect_pc = 0;
    for (int i = 0; i < 8; i++) rom_mem[i] = 32'h1000_0000 + i;
    m_pc = RESET_PC; m_idle = 1; m_halt = 0; m_fault = 0;
    m_valid = 0; m_instr = 0; m_opc = 0;

    // Reset state, then sequential stream running off the end of the ROM.
    do_reset();
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_fault", {31'b0, fault}, 32'h0);
    tick();
    check("latency_edge1", {31'b0, out_valid}, 32'h0);
    tick();
    check("latency_edge2", {31'b0, out_valid}, 32'h1);
    check("first_pc", out_pc, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    check("end_fault", {31'b0, fault}, 32'h1);
    check("end_rom_en", {31'b0, rom_en}, 32'h0);

    // Back-pressure for three cycles after the first word.
    do_reset();
    tick(); tick();
    out_ready = 0;
    for (int i = 0; i < 3; i++) tick();
    check("stall_pc", out_pc, 32'h0);
    check("stall_rom_pc", rom_pc, 32'h4);
    out_ready = 1;
    tick();
    check("release_pc", out_pc, 32'h4);
    tick();

    // Redirect to 16 while word 4 is held.
    do_reset();
    tick(); tick(); tick();
    redirect_valid = 1; redirect_pc = 32'd16;
    tick();
    redirect_valid = 0;
    check("redir_flush", {31'b0, out_valid}, 32'h0);
    tick();
    check("redir_pc", out_pc, 32'd16);
    check("redir_instr", out_instr, 32'h1000_0004);

    // Misaligned redirect halts; a legal one recovers.
    redirect_valid = 1; redirect_pc = 32'd6;
    tick();
    redirect_valid = 0;
    tick(); tick();
    check("misalign_fault", {31'b0, fault}, 32'h1);
    redirect_valid = 1; redirect_pc = 32'd8;
    tick();
    redirect_valid = 0;
    check("recover_fault", {31'b0, fault}, 32'h0);
    tick();
    check("recover_pc", out_pc, 32'd8);

    // Reset pulse in mid-stream.
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset_pc", out_pc, 32'd12);
    do_reset();
    check("mid_reset_valid", {31'b0, out_valid}, 32'h0);
    tick(); tick(); tick();

    // Redirect in the same cycle decode accepts word 8.
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1; redirect_pc = 32'd20;
    tick();
    redirect_valid = 0;
    tick(); tick();
    check("same_cycle_pc", out_pc, 32'd24);

    // Randomized traffic with random ROM contents.
    for (int i = 0; i < 8; i++) rom_mem[i] = $urandom;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset     = ($urandom % 100) == 0;
      out_ready = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 12) == 0;
      case ($urandom % 4)
        0, 1:    redirect_pc = ($urandom % 9) * 4;
        2:       redirect_pc = $urandom % 40;
        default: redirect_pc = ($urandom % 2) ? $urandom : 32'hFFFF_FFFC;
      endcase
      tick();
    end
    reset = 0; redirect_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
